// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-word layout and fixed register indices.
// Imported by the MEM, decode and write-back stages.
package mips_pkg;

    localparam int CTRL_W        = 11;
    localparam int CTRL_REGWRITE = 10;
    localparam int CTRL_MEMWRITE = 9;
    localparam int CTRL_MEMCLS_HI = 5;
    localparam int CTRL_MEMCLS_LO = 3;

    localparam logic [2:0] MEMCLS_MEM = 3'b000;

    localparam int REG_ZERO     = 0;
    localparam int TEST_REG_IDX = 4;

    // True when the control word marks a load/store class operation.
    function automatic logic is_mem_class(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMCLS_HI:CTRL_MEMCLS_LO] == MEMCLS_MEM;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: one write port, two combinational read ports with
// same-cycle write-to-read bypass. Register 0 is hardwired to zero.
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [$clog2(SIZE)-1:0] i_wr_addr,
    input  logic [SIZE-1:0]         i_wr_data,
    input  logic [$clog2(SIZE)-1:0] i_rd_addr_a,
    input  logic [$clog2(SIZE)-1:0] i_rd_addr_b,
    output logic [SIZE-1:0]         o_rd_data_a,
    output logic [SIZE-1:0]         o_rd_data_b,
    output logic [SIZE-1:0]         o_test_reg
);

    localparam int AW = $clog2(SIZE);

    logic [SIZE-1:0] r_regs [SIZE];
    logic            w_wr_live;

    assign w_wr_live = i_we && (i_wr_addr != AW'(REG_ZERO));

    // NOTE: the array is cleared on reset because software relies on every register
    // reading zero after reset; this makes it flops, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            // NOTE: non-blocking so every reader in this edge sees the old contents.
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // NOTE: every output gets a default first so no path through the mux infers a latch.
    always_comb begin
        o_rd_data_a = '0;
        if (i_rd_addr_a == AW'(REG_ZERO)) begin
            o_rd_data_a = '0;
        end else if (w_wr_live && (i_rd_addr_a == i_wr_addr)) begin
            o_rd_data_a = i_wr_data;
        end else begin
            o_rd_data_a = r_regs[i_rd_addr_a];
        end
    end

    always_comb begin
        o_rd_data_b = '0;
        if (i_rd_addr_b == AW'(REG_ZERO)) begin
            o_rd_data_b = '0;
        end else if (w_wr_live && (i_rd_addr_b == i_wr_addr)) begin
            o_rd_data_b = i_wr_data;
        end else begin
            o_rd_data_b = r_regs[i_rd_addr_b];
        end
    end

    assign o_test_reg = r_regs[TEST_REG_IDX];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: decodes the MEM control word, commits into the register file,
// keeps a registered commit record and a retired-instruction counter.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int SIZE   = 32,
    parameter int CTRL_W = mips_pkg::CTRL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SIZE-1:0]         ALUresult_MEM,
    input  logic [$clog2(SIZE)-1:0] writeReg_MEM,
    input  logic [CTRL_W-1:0]       control_MEM,
    input  logic [$clog2(SIZE)-1:0] rdAddrA,
    input  logic [$clog2(SIZE)-1:0] rdAddrB,
    output logic [SIZE-1:0]         rdDataA,
    output logic [SIZE-1:0]         rdDataB,
    output logic                    wbValid,
    output logic [$clog2(SIZE)-1:0] wbReg,
    output logic [SIZE-1:0]         wbData,
    output logic [SIZE-1:0]         retireCount,
    output logic [SIZE-1:0]         testReg
);

    localparam int AW = $clog2(SIZE);

    logic            w_reg_write;
    logic            w_mem_write;
    logic            w_we;
    logic            w_retire;

    logic            r_wb_valid;
    logic [AW-1:0]   r_wb_reg;
    logic [SIZE-1:0] r_wb_data;
    logic [SIZE-1:0] r_retire_count;

    assign w_reg_write = control_MEM[CTRL_REGWRITE];
    assign w_mem_write = control_MEM[CTRL_MEMWRITE];

    // Stores never write registers; a write seen while reset is held is discarded,
    // which also keeps the read ports at zero throughout reset.
    assign w_we     = w_reg_write && !w_mem_write && (writeReg_MEM != AW'(REG_ZERO)) && !rst;
    assign w_retire = (control_MEM != '0);

    regfile_2r1w #(
        .SIZE (SIZE)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .i_we        (w_we),
        .i_wr_addr   (writeReg_MEM),
        .i_wr_data   (ALUresult_MEM),
        .i_rd_addr_a (rdAddrA),
        .i_rd_addr_b (rdAddrB),
        .o_rd_data_a (rdDataA),
        .o_rd_data_b (rdDataB),
        .o_test_reg  (testReg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_reg   <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_we;
            if (w_we) begin
                r_wb_reg  <= writeReg_MEM;
                r_wb_data <= ALUresult_MEM;
            end
        end
    end

    // Bubbles do not retire; everything else does, including stores and r0 writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_count <= '0;
        end else if (w_retire) begin
            r_retire_count <= r_retire_count + SIZE'(1);
        end
    end

    assign wbValid     = r_wb_valid;
    assign wbReg       = r_wb_reg;
    assign wbData      = r_wb_data;
    assign retireCount = r_retire_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: a 32-bit instance for the main
// function and an 8-bit instance to reach the retire-counter wrap quickly.
module tb_wb_regfile;

    logic        clk;
    logic        rst;

    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [10:0] ctrl;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] rda;
    logic [31:0] rdb;
    logic        wbv;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic [31:0] ret;
    logic [31:0] treg;

    logic [7:0]  alu2;
    logic [2:0]  wreg2;
    logic [10:0] ctrl2;
    logic [2:0]  ra2;
    logic [2:0]  rb2;
    logic [7:0]  rda2;
    logic [7:0]  rdb2;
    logic        wbv2;
    logic [2:0]  wbr2;
    logic [7:0]  wbd2;
    logic [7:0]  ret2;
    logic [7:0]  treg2;

    int n_tests = 0;
    int n_fail  = 0;

    wb_regfile #(.SIZE(32), .CTRL_W(11)) dut (
        .clk           (clk),
        .rst           (rst),
        .ALUresult_MEM (alu),
        .writeReg_MEM  (wreg),
        .control_MEM   (ctrl),
        .rdAddrA       (ra),
        .rdAddrB       (rb),
        .rdDataA       (rda),
        .rdDataB       (rdb),
        .wbValid       (wbv),
        .wbReg         (wbr),
        .wbData        (wbd),
        .retireCount   (ret),
        .testReg       (treg)
    );

    wb_regfile #(.SIZE(8), .CTRL_W(11)) dut8 (
        .clk           (clk),
        .rst           (rst),
        .ALUresult_MEM (alu2),
        .writeReg_MEM  (wreg2),
        .control_MEM   (ctrl2),
        .rdAddrA       (ra2),
        .rdAddrB       (rb2),
        .rdDataA       (rda2),
        .rdDataB       (rdb2),
        .wbValid       (wbv2),
        .wbReg         (wbr2),
        .wbData        (wbd2),
        .retireCount   (ret2),
        .testReg       (treg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        alu   = '0; wreg  = '0; ctrl  = '0; ra  = '0; rb  = '0;
        alu2  = '0; wreg2 = '0; ctrl2 = '0; ra2 = '0; rb2 = '0;

        // Reset state before any edge
        #2;
        ra = 5'd4; rb = 5'd7;
        #0.5;
        check("rst_rda", rda, 32'h0);
        check("rst_wbv", {31'b0, wbv}, 32'h0);
        check("rst_ret", ret, 32'h0);
        rst = 1'b0;

        // Basic write reg4 <- 0xAB, bypass visible before the edge
        ctrl = 11'h400; wreg = 5'd4; alu = 32'h0000_00AB; ra = 5'd4;
        #1;
        check("wr4_bypass", rda, 32'h0000_00AB);
        tick();
        ctrl = 11'h000;
        #1;
        check("wr4_rda", rda, 32'h0000_00AB);
        check("wr4_treg", treg, 32'h0000_00AB);
        check("wr4_wbv", {31'b0, wbv}, 32'h1);
        check("wr4_wbr", {27'b0, wbr}, 32'd4);
        check("wr4_wbd", wbd, 32'h0000_00AB);
        check("wr4_ret", ret, 32'd1);

        // Same-cycle bypass on both ports
        ctrl = 11'h400; wreg = 5'd7; alu = 32'hDEAD_BEEF; ra = 5'd7; rb = 5'd7;
        #1;
        check("byp_rda", rda, 32'hDEAD_BEEF);
        check("byp_rdb", rdb, 32'hDEAD_BEEF);
        check("byp_treg", treg, 32'h0000_00AB);
        tick();
        check("byp_wbr", {27'b0, wbr}, 32'd7);
        check("byp_wbd", wbd, 32'hDEAD_BEEF);
        check("byp_ret", ret, 32'd2);

        // RegWrite to r0 is dropped but retires
        ctrl = 11'h400; wreg = 5'd0; alu = 32'h0000_1234; ra = 5'd0;
        #1;
        check("r0_nobyp", rda, 32'h0);
        tick();
        check("r0_rda", rda, 32'h0);
        check("r0_wbv", {31'b0, wbv}, 32'h0);
        check("r0_wbr_hold", {27'b0, wbr}, 32'd7);
        check("r0_wbd_hold", wbd, 32'hDEAD_BEEF);
        check("r0_ret", ret, 32'd3);

        // Store to reg5 never writes the register file
        ctrl = 11'h600; wreg = 5'd5; alu = 32'h5555_5555; ra = 5'd5;
        #1;
        check("st_nobyp", rda, 32'h0);
        tick();
        check("st_rda", rda, 32'h0);
        check("st_wbv", {31'b0, wbv}, 32'h0);
        check("st_ret", ret, 32'd4);

        // Highest register, then read it on port B
        ctrl = 11'h400; wreg = 5'd31; alu = 32'h8000_0001; ra = 5'd7; rb = 5'd31;
        tick();
        ctrl = 11'h000;
        #1;
        check("r31_rdb", rdb, 32'h8000_0001);
        check("r31_rda7", rda, 32'hDEAD_BEEF);
        check("r31_ret", ret, 32'd5);

        // Three bubbles with junk data/reg: nothing changes
        ctrl = 11'h000; wreg = 5'd9; alu = 32'hFFFF_FFFF; ra = 5'd9; rb = 5'd4;
        tick(); tick(); tick();
        check("bub_rda9", rda, 32'h0);
        check("bub_rdb4", rdb, 32'h0000_00AB);
        check("bub_ret", ret, 32'd5);
        check("bub_wbv", {31'b0, wbv}, 32'h0);
        check("bub_wbr", {27'b0, wbr}, 32'd31);
        check("bub_wbd", wbd, 32'h8000_0001);

        // Mid-cycle reset with a write pending: cleared immediately, write lost
        ctrl = 11'h400; wreg = 5'd4; alu = 32'h0000_0077; ra = 5'd4; rb = 5'd7;
        #2;
        rst = 1'b1;
        #1;
        check("mrst_rda", rda, 32'h0);
        check("mrst_rdb", rdb, 32'h0);
        check("mrst_treg", treg, 32'h0);
        check("mrst_wbv", {31'b0, wbv}, 32'h0);
        check("mrst_wbr", {27'b0, wbr}, 32'd0);
        check("mrst_wbd", wbd, 32'h0);
        check("mrst_ret", ret, 32'h0);
        tick();
        check("mrst_edge_treg", treg, 32'h0);
        check("mrst_edge_ret", ret, 32'h0);
        rst = 1'b0;
        tick();
        ctrl = 11'h000;
        #1;
        check("post_treg", treg, 32'h0000_0077);
        check("post_wbv", {31'b0, wbv}, 32'h1);
        check("post_ret", ret, 32'd1);
        check("post_rdb7", rdb, 32'h0);

        // Counter wrap on the 8-bit instance: 255 stores, then one more
        ctrl2 = 11'h600; wreg2 = 3'd4; alu2 = 8'h5A;
        for (int i = 0; i < 255; i++) begin
            tick();
        end
        check("wrap_ff", {24'b0, ret2}, 32'h0000_00FF);
        tick();
        check("wrap_zero", {24'b0, ret2}, 32'h0);
        check("wrap_treg", {24'b0, treg2}, 32'h0);
        ctrl2 = 11'h000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
